fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer sitting directly upstream of the 16-bit word memory. It holds the program counter and drives the memory's address-load and read strobes in the order the memory needs: address register first, registered read next, data a cycle later. It captures each returned word into an instruction register and presents it downstream with a valid/ready handshake. It also accepts jump redirects and a halt request from the control path.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- MEM_SIZE, 256, memory depth in words; must be a power of two; PC wraps modulo MEM_SIZE
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- halt  in  1  stop issuing new fetches
- jump_en  in  1  one-cycle redirect request
- jump_addr  in  16  redirect target
- mem_addr_en  out  1  load memory address register
- mem_addr  out  16  address driven to memory
- mem_out_en  out  1  memory read strobe
- mem_out  in  16  memory read data, registered inside memory
- instr  out  16  fetched instruction word
- instr_pc  out  16  address instr was fetched from
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  downstream accepts

## Operation
- States: IDLE, ADDR, READ, CAPT, VALID. Moore outputs: mem_addr_en=1 in ADDR, mem_out_en=1 in READ, instr_valid=1 in VALID; otherwise 0. mem_addr = pc in all states.
- IDLE: go to ADDR if !halt, else stay.
- ADDR -> READ -> CAPT unconditionally.
- CAPT: instr <= mem_out, instr_pc <= pc, pc <= (pc+1) mod MEM_SIZE; go to VALID.
- VALID: hold instr/instr_pc stable. On instr_valid && instr_ready, go to IDLE if halt, else go to ADDR.
- halt never aborts an in-flight fetch. It is sampled only in IDLE and on the VALID handshake.
- jump_en (any state, highest priority): pc <= jump_addr mod MEM_SIZE; go to ADDR if !halt, else IDLE. Any fetch in flight is discarded. A jump in CAPT suppresses both the capture and the increment. A jump in VALID together with ready counts as the instruction being consumed. A jump in VALID without ready drops the instruction.
- Reset (any state, overrides jump): state=IDLE, pc=RESET_PC mod MEM_SIZE, instr=0, instr_pc=0. With reset, every output is 0 except mem_addr = RESET_PC.
- The block never writes memory; the memory's write enable is tied low at the top level.

## Timing
- First fetch: rst deasserted with halt=0 at edge E0. Cycle after E0 is IDLE. instr_valid first rises 4 cycles later (IDLE, ADDR, READ, CAPT, then VALID).
- Fetch latency, ADDR entry to VALID: 3 cycles.
- Throughput with instr_ready held high: 1 instruction per 4 cycles (ADDR, READ, CAPT, VALID).
- mem_out is sampled only in CAPT. It is valid because mem_out_en was high in the preceding READ cycle.
- instr_valid falls the cycle after the handshake, or after a jump or reset.

## Configuration
- FETCH_OVERLAP_EN defined: mem_addr_en is also 1 in VALID, with mem_addr = pc (already incremented). On the handshake without halt or jump, the FSM goes VALID -> READ, skipping ADDR. Throughput is 1 instruction per 3 cycles. Jump and halt behaviour are unchanged.
- FETCH_OVERLAP_EN undefined: behaviour exactly as in Operation; mem_addr_en is never high in VALID.

## Structure
- Package fetch_pkg: state enum type, state encodings, and a 16-bit word typedef.
- One sub-module, fetch_pc: the PC register with reset-load, increment-mod-MEM_SIZE and jump-load. Priority is rst > jump > inc.
- FSM, instruction register and handshake live in fetch_unit.

## Test plan
- Reset release, mem[0]=16'h1234, mem[1]=16'hABCD, ready=1 -> instr_valid at cycle 4 with instr=16'h1234, instr_pc=0. Next valid at cycle 8 (cycle 7 with FETCH_OVERLAP_EN) with instr=16'hABCD, instr_pc=1.
- Hold ready=0 for 5 cycles while in VALID -> instr, instr_pc and instr_valid stable. mem_addr_en=0 and mem_out_en=0 (mem_addr_en=1 with FETCH_OVERLAP_EN). One acceptance on ready.
- jump_en with jump_addr=16'h0010 during READ, mem[16'h10]=16'h5555 -> old word never presented. Next valid instr=16'h5555, instr_pc=16'h0010.
- MEM_SIZE=256, jump to 16'h01FF -> instr_pc=16'h00FF, then next instr_pc=16'h0000.
- halt raised during READ -> fetch completes and is presented. After the handshake: IDLE, no mem strobes until halt falls, then ADDR next cycle.
- rst asserted in CAPT -> next cycle instr_valid=0, instr=0, pc=RESET_PC, state IDLE. Fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_READ  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_VALID = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with reset-load, jump-load and increment, all modulo MEM_SIZE.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter word_t       RESET_PC = 16'h0000,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc_en,
    input  logic  jump_en,
    input  word_t jump_addr,
    output word_t pc
);

    localparam word_t ADDR_MASK = WORD_W'(MEM_SIZE - 1);

    // PC update; rst beats jump beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC & ADDR_MASK;
        end else if (jump_en) begin
            pc <= jump_addr & ADDR_MASK;
        end else if (inc_en) begin
            pc <= (pc + WORD_W'(1)) & ADDR_MASK;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer driving a registered-read word memory.
// Optional build macro FETCH_OVERLAP_EN overlaps the next address load with VALID.
// The memory write enable is tied low by the integrating top; this block only reads.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t       RESET_PC = 16'h0000,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  halt,
    input  logic  jump_en,
    input  word_t jump_addr,
    output logic  mem_addr_en,
    output word_t mem_addr,
    output logic  mem_out_en,
    input  word_t mem_out,
    output word_t instr,
    output word_t instr_pc,
    output logic  instr_valid,
    input  logic  instr_ready
);

    state_t state_q;
    state_t state_d;
    logic   capture;
    logic   addr_en_d;
    logic   out_en_d;
    logic   valid_d;
    word_t  pc;

    fetch_pc #(
        .RESET_PC (RESET_PC),
        .MEM_SIZE (MEM_SIZE)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (capture),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .pc        (pc)
    );

    assign mem_addr = pc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, capture strobe and next-cycle output decode; jump discards any fetch
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (jump_en) begin
            state_d = halt ? ST_IDLE : ST_ADDR;
        end else begin
            case (state_q)
                ST_IDLE:  if (!halt) state_d = ST_ADDR;
                ST_ADDR:  state_d = ST_READ;
                ST_READ:  state_d = ST_CAPT;
                ST_CAPT: begin
                    capture = 1'b1;
                    state_d = ST_VALID;
                end
                ST_VALID: begin
                    if (instr_ready) begin
`ifdef FETCH_OVERLAP_EN
                        state_d = halt ? ST_IDLE : ST_READ;
`else
                        state_d = halt ? ST_IDLE : ST_ADDR;
`endif
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
`ifdef FETCH_OVERLAP_EN
        addr_en_d = (state_d == ST_ADDR) || (state_d == ST_VALID);
`else
        addr_en_d = (state_d == ST_ADDR);
`endif
        out_en_d = (state_d == ST_READ);
        valid_d  = (state_d == ST_VALID);
    end

    // Registered Moore outputs, aligned with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_en <= 1'b0;
            mem_out_en  <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            mem_addr_en <= addr_en_d;
            mem_out_en  <= out_en_d;
            instr_valid <= valid_d;
        end
    end

    // Instruction register: loads only on a non-redirected CAPT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (capture) begin
            instr    <= mem_out;
            instr_pc <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for fetch_unit.
module tb_fetch_unit;

`ifdef FETCH_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        jump_en = 1'b0;
    logic [15:0] jump_addr = 16'h0000;
    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_out_en;
    logic [15:0] mem_out;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic [15:0] areg;

    fetch_unit #(
        .RESET_PC (16'h0000),
        .MEM_SIZE (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .mem_addr_en (mem_addr_en),
        .mem_addr    (mem_addr),
        .mem_out_en  (mem_out_en),
        .mem_out     (mem_out),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    // Word memory model: address register, then registered read
    always @(posedge clk) begin
        if (mem_addr_en) areg <= mem_addr;
        if (mem_out_en) mem_out <= mem[areg[7:0]];
    end

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [15:0] jaddr;
        logic        rdy;
        logic        e_valid;
        logic        e_aen;
        logic        e_oen;
        logic [15:0] e_instr;
        logic [15:0] e_ipc;
        logic [15:0] e_maddr;
    } vec_t;

    vec_t vecs [32];
    int   nvec = 0;

    task automatic add_vec(input logic r, input logic j, input logic [15:0] ja, input logic rd,
                           input logic ev, input logic ea, input logic eo,
                           input logic [15:0] ei, input logic [15:0] ep, input logic [15:0] em);
        vecs[nvec] = '{r, j, ja, rd, ev, ea, eo, ei, ep, em};
        nvec++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL wait_valid: instr_valid=0 after %0d cycles, expected 1", cyc);
        end
    endtask

    task automatic chk_strobes(input string name, input logic ev, input logic ea, input logic eo);
        chk({name, ".valid"}, 16'(instr_valid), 16'(ev));
        chk({name, ".aen"}, 16'(mem_addr_en), 16'(ea));
        chk({name, ".oen"}, 16'(mem_out_en), 16'(eo));
    endtask

    initial begin
        int cyc;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        mem[0]     = 16'h1234;
        mem[1]     = 16'hABCD;
        mem[16]    = 16'h5555;
        mem[255]   = 16'hBEEF;
        mem_out    = 16'h0000;
        areg       = 16'h0000;

        // rst  jmp  jaddr     rdy | valid aen   oen   instr     ipc    maddr
        add_vec(1, 1, 16'h0033, 0,   0,   0,    0,    16'h0000, 16'h0, 16'h0);
        add_vec(0, 0, 16'h0000, 1,   0,   1,    0,    16'h0000, 16'h0, 16'h0);
        add_vec(0, 0, 16'h0000, 1,   0,   0,    1,    16'h0000, 16'h0, 16'h0);
        add_vec(0, 0, 16'h0000, 1,   0,   0,    0,    16'h0000, 16'h0, 16'h0);
        add_vec(0, 0, 16'h0000, 1,   1,   OVL,  0,    16'h1234, 16'h0, 16'h1);
        add_vec(0, 0, 16'h0000, 1,   0,   !OVL, OVL,  16'h1234, 16'h0, 16'h1);
        add_vec(0, 0, 16'h0000, 0,   0,   0,    !OVL, 16'h1234, 16'h0, 16'h1);
        add_vec(0, 0, 16'h0000, 0,   OVL, OVL,  0,    OVL ? 16'hABCD : 16'h1234,
                OVL ? 16'h1 : 16'h0, OVL ? 16'h2 : 16'h1);
        for (int i = 0; i < 6; i++)
            add_vec(0, 0, 16'h0000, 0, 1, OVL, 0, 16'hABCD, 16'h1, 16'h2);
        add_vec(0, 0, 16'h0000, 1,   0,   !OVL, OVL,  16'hABCD, 16'h1, 16'h2);
        add_vec(0, 0, 16'h0000, 0,   0,   0,    !OVL, 16'hABCD, 16'h1, 16'h2);

        for (int i = 0; i < nvec; i++) begin
            rst         = vecs[i].rst;
            jump_en     = vecs[i].jmp;
            jump_addr   = vecs[i].jaddr;
            instr_ready = vecs[i].rdy;
            step();
            chk_strobes($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_aen, vecs[i].e_oen);
            chk($sformatf("vec%0d.maddr", i), mem_addr, vecs[i].e_maddr);
            chk($sformatf("vec%0d.instr", i), instr, vecs[i].e_instr);
            chk($sformatf("vec%0d.ipc", i), instr_pc, vecs[i].e_ipc);
        end
        jump_en = 1'b0;
        instr_ready = 1'b0;

        // Jump during READ discards the in-flight word
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        chk_strobes("jr.pre", 1'b0, 1'b0, 1'b1);
        jump_en = 1'b1; jump_addr = 16'h0010;
        step();
        jump_en = 1'b0;
        chk_strobes("jr.addr", 1'b0, 1'b1, 1'b0);
        chk("jr.maddr", mem_addr, 16'h0010);
        wait_valid(10, cyc);
        chk("jr.lat", 16'(cyc), 16'd3);
        chk("jr.instr", instr, 16'h5555);
        chk("jr.ipc", instr_pc, 16'h0010);

        // Jump in VALID without ready drops the word; target wraps modulo 256
        jump_en = 1'b1; jump_addr = 16'h01FF;
        step();
        jump_en = 1'b0;
        chk_strobes("jw.addr", 1'b0, 1'b1, 1'b0);
        chk("jw.maddr", mem_addr, 16'h00FF);
        wait_valid(10, cyc);
        chk("jw.instr", instr, 16'hBEEF);
        chk("jw.ipc", instr_pc, 16'h00FF);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        wait_valid(10, cyc);
        chk("jw.lat", 16'(cyc), OVL ? 16'd2 : 16'd3);
        chk("jw.wrap_ipc", instr_pc, 16'h0000);
        chk("jw.wrap_instr", instr, 16'h1234);

        // Halt raised during READ: fetch completes, then IDLE until halt falls
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        halt = 1'b1;
        wait_valid(10, cyc);
        chk("h.lat", 16'(cyc), 16'd2);
        chk("h.instr", instr, 16'h1234);
        chk("h.ipc", instr_pc, 16'h0000);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk_strobes("h.idle", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_strobes($sformatf("h.hold%0d", i), 1'b0, 1'b0, 1'b0);
        end
        halt = 1'b0;
        step();
        chk_strobes("h.resume", 1'b0, 1'b1, 1'b0);
        chk("h.maddr", mem_addr, 16'h0001);

        // Reset asserted in CAPT clears the instruction register and restarts at RESET_PC
        step(); step();
        chk("rc.instr_pre", instr, 16'h1234);
        rst = 1'b1; step(); rst = 1'b0;
        chk_strobes("rc.post", 1'b0, 1'b0, 1'b0);
        chk("rc.instr", instr, 16'h0000);
        chk("rc.ipc", instr_pc, 16'h0000);
        chk("rc.maddr", mem_addr, 16'h0000);
        wait_valid(10, cyc);
        chk("rc.lat", 16'(cyc), 16'd4);
        chk("rc.instr2", instr, 16'h1234);

        // Jump in CAPT suppresses capture and increment
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        if (!OVL) step();
        step();
        jump_en = 1'b1; jump_addr = 16'h0010;
        step();
        jump_en = 1'b0;
        chk("jc.instr", instr, 16'h1234);
        chk("jc.ipc", instr_pc, 16'h0000);
        chk("jc.maddr", mem_addr, 16'h0010);
        chk_strobes("jc.addr", 1'b0, 1'b1, 1'b0);
        wait_valid(10, cyc);
        chk("jc.ipc2", instr_pc, 16'h0010);
        chk("jc.instr2", instr, 16'h5555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
